// File: rtl/weight_dist_if.sv
// Weight distributor bus: config stream, weight beat stream,
// and the per-channel FWFT outputs towards the PE columns.
interface weight_dist_if #(
    parameter int NUM_CH   = 64,
    parameter int LANES    = 8,
    parameter int LANE_W   = 16,
    parameter int WEIGHT_W = 12
);
    logic                       s_config_valid;
    logic                       s_config_ready;
    logic [31:0]                s_config_data;
    logic                       s_weight_valid;
    logic                       s_weight_ready;
    logic [LANES*LANE_W-1:0]    s_weight;
    logic [NUM_CH-1:0]          m_weight_valid;
    logic [NUM_CH*WEIGHT_W-1:0] m_weight_data;
    logic [NUM_CH-1:0]          m_weight_ready;

    modport master (
        output s_config_valid, s_config_data,
        input  s_config_ready,
        output s_weight_valid, s_weight,
        input  s_weight_ready,
        input  m_weight_valid, m_weight_data,
        output m_weight_ready
    );

    modport slave (
        input  s_config_valid, s_config_data,
        output s_config_ready,
        input  s_weight_valid, s_weight,
        output s_weight_ready,
        output m_weight_valid, m_weight_data,
        input  m_weight_ready
    );
endinterface

// File: rtl/weight_dist_array.sv
// Weight distributor: splits wide beats into per-channel FWFT FIFOs,
// repeating for a configured number of rounds, then strobes done.
module weight_dist_array #(
    parameter int NUM_CH     = 64,
    parameter int LANES      = 8,
    parameter int LANE_W     = 16,
    parameter int WEIGHT_W   = 12,
    parameter int FIFO_DEPTH = 512,
    parameter int PF_MARGIN  = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    weight_dist_if.slave     bus,
    output logic [CNT_W-1:0] weight_dcnt,
    output logic             done,
    output logic [2:0]       status
);
    localparam int GRPS  = NUM_CH / LANES;
    localparam int GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] PF_LEVEL = CNT_W'(FIFO_DEPTH - PF_MARGIN);
    localparam logic [GRP_W-1:0] GRP_MAX  = GRP_W'(GRPS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        LOAD  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                     state_q, state_n;
    logic [23:0]                rounds_q, rdone_q;
    logic [GRP_W-1:0]           grp_q, last_grp_q, last_grp_d;
    logic [15:0]                act_req;
    logic                       cfg_hs, beat_hs, last_beat;
    logic [NUM_CH-1:0]          push, pop, pf, act, vld;
    logic [CNT_W-1:0]           cnt [NUM_CH];
    logic [NUM_CH*WEIGHT_W-1:0] head;
    logic [CH_W-1:0]            last_ch;
    logic                       unused_in;

    assign unused_in = ^{bus.s_config_data[31:24], bus.s_weight};

    assign cfg_hs    = bus.s_config_valid & bus.s_config_ready;
    assign beat_hs   = bus.s_weight_valid & bus.s_weight_ready;
    assign last_beat = grp_q == last_grp_q;

    // active_ch of 0 or above NUM_CH means all channels; else round up
    assign act_req    = bus.s_config_data[15:0];
    assign last_grp_d = (act_req == 16'd0 || act_req > 16'(NUM_CH))
                      ? GRP_MAX
                      : GRP_W'((act_req - 16'd1) / 16'(LANES));
    assign last_ch    = CH_W'((32'(last_grp_q) + 32'd1) * LANES - 1);

    assign bus.s_config_ready = rst_n & (state_q == IDLE || state_q == CFG);
    assign bus.s_weight_ready = (state_q == LOAD) & ~|(pf & act);
    assign bus.m_weight_valid = vld;
    assign bus.m_weight_data  = head;
    assign done               = state_q == DONE;
    assign status             = state_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // FSM next-state
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (cfg_hs) state_n = CFG;
            CFG:     if (cfg_hs) state_n = (rounds_q == 24'd0) ? DONE : LOAD;
            LOAD:    if (beat_hs && last_beat) state_n = ROUND;
            ROUND:   state_n = (rdone_q + 24'd1 < rounds_q) ? LOAD : DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // config capture, beat group and round counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rounds_q   <= '0;
            rdone_q    <= '0;
            grp_q      <= '0;
            last_grp_q <= GRP_MAX;
        end else begin
            if (state_q == IDLE && cfg_hs) rounds_q <= bus.s_config_data[23:0];
            if (state_q == CFG && cfg_hs) begin
                last_grp_q <= last_grp_d;
                rdone_q    <= '0;
                grp_q      <= '0;
            end
            if (beat_hs) grp_q <= grp_q + GRP_W'(1);
            if (state_q == ROUND) begin
                rdone_q <= rdone_q + 24'd1;
                grp_q   <= '0;
            end
        end
    end

    // one-cycle-late copy of the highest active channel's occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) weight_dcnt <= '0;
        else        weight_dcnt <= cnt[last_ch];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int LN = c % LANES;
        localparam logic [GRP_W-1:0] G = GRP_W'(c / LANES);

        logic [WEIGHT_W-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]       wp_q, rp_q;
        logic [CNT_W-1:0]    cnt_q;

        assign act[c]  = G <= last_grp_q;
        assign push[c] = beat_hs & (grp_q == G);
        assign pop[c]  = bus.m_weight_ready[c] & (cnt_q != '0);
        assign pf[c]   = cnt_q >= PF_LEVEL;
        assign vld[c]  = cnt_q != '0;
        assign cnt[c]  = cnt_q;
        assign head[c*WEIGHT_W +: WEIGHT_W] = mem[rp_q];

        // storage write; contents need no reset since occupancy gates valid
        always_ff @(posedge clk) begin
            if (push[c]) mem[wp_q] <= bus.s_weight[(LANES-1-LN)*LANE_W +: WEIGHT_W];
        end

        // pointers and occupancy; push+pop leaves the count unchanged
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push[c]) wp_q <= wp_q + AW'(1);
                if (pop[c])  rp_q <= rp_q + AW'(1);
                if (push[c] && !pop[c])      cnt_q <= cnt_q + CNT_W'(1);
                else if (!push[c] && pop[c]) cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_weight_dist_array.sv
// Bench for weight_dist_array: random beats against a queue-per-channel
// reference model, plus directed reset, backpressure and edge cases.
module tb_weight_dist_array;
    localparam int NUM_CH = 64;
    localparam int LANES  = 8;
    localparam int LANE_W = 16;
    localparam int WW     = 12;
    localparam int DEPTH  = 512;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] weight_dcnt;
    logic             done;
    logic [2:0]       status;

    weight_dist_if #(
        .NUM_CH(NUM_CH), .LANES(LANES), .LANE_W(LANE_W), .WEIGHT_W(WW)
    ) bus ();

    weight_dist_array dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .weight_dcnt(weight_dcnt),
        .done(done),
        .status(status)
    );

    always #5 clk = ~clk;

    int total = 0, passes = 0, fails = 0;
    logic [WW-1:0] q [NUM_CH][$];
    int bpr = 8, beats = 0, dones = 0, last_ch = 63;
    int exp_prev = 3, cur_rounds = 0;
    logic [2:0] prev_status = 3'd0;
    bit hs_c, hs_w, force123, rnd_mready;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit any_pending();
        for (int c = 0; c < NUM_CH; c++)
            if (q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_beat();
        bus.s_weight = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (force123 && (beats % bpr == 0))
            bus.s_weight[(LANES-1)*LANE_W +: WW] = 12'h123;
    endtask

    // one clock: check at negedge, update model, then advance
    task automatic tick();
        logic [NUM_CH-1:0] expv;
        int g;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) expv[c] = (q[c].size() != 0);
        chk("m_valid", bus.m_weight_valid, expv);
        chk("cfg_ready", bus.s_config_ready, rst_n && status <= 3'd1);
        if (status != 3'd2) chk("w_ready_off", bus.s_weight_ready, 1'b0);
        if (done) begin
            dones++;
            chk("done_after", prev_status, exp_prev);
        end
        prev_status = status;
        hs_c = bus.s_config_valid && bus.s_config_ready;
        hs_w = bus.s_weight_valid && bus.s_weight_ready;
        for (int c = 0; c < NUM_CH; c++)
            if (bus.m_weight_ready[c] && bus.m_weight_valid[c] && q[c].size() != 0)
                chk($sformatf("data_ch%0d", c),
                    bus.m_weight_data[c*WW +: WW], q[c].pop_front());
        if (hs_w) begin
            g = beats % bpr;
            for (int i = 0; i < LANES; i++)
                q[g*LANES+i].push_back(bus.s_weight[(LANES-1-i)*LANE_W +: WW]);
            beats++;
        end
        @(posedge clk);
        #1;
        if (hs_w) new_beat();
        if (rnd_mready) bus.m_weight_ready = {$urandom(), $urandom()};
    endtask

    task automatic do_config(input logic [23:0] rounds, input logic [15:0] act);
        int k, a;
        bus.s_config_valid = 1'b1;
        bus.s_config_data  = {8'($urandom()), rounds};
        k = 0;
        do begin tick(); k++; end while (!hs_c && k < 20);
        chk("cfg0_hs", hs_c, 1'b1);
        chk("cfg_state", status, 3'd1);
        a = int'(act);
        if (a == 0 || a > NUM_CH) a = NUM_CH;
        else a = ((a + LANES - 1) / LANES) * LANES;
        bpr = a / LANES;
        last_ch = a - 1;
        beats = 0;
        dones = 0;
        cur_rounds = int'(rounds);
        exp_prev = (rounds == 24'd0) ? 1 : 3;
        bus.s_config_data = {16'($urandom()), act};
        k = 0;
        do begin tick(); k++; end while (!hs_c && k < 20);
        chk("cfg1_hs", hs_c, 1'b1);
        bus.s_config_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats < n && k < budget) begin tick(); k++; end
        chk("beats_reached", beats, n);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (dones == 0 && k < budget) begin tick(); k++; end
        chk("done_seen", dones, 1);
        tick();
        tick();
        chk("done_once", dones, 1);
        chk("back_idle", status, 3'd0);
        chk("beat_total", beats, cur_rounds * bpr);
    endtask

    task automatic drain();
        int k = 0;
        bus.s_weight_valid = 1'b0;
        rnd_mready = 1'b0;
        bus.m_weight_ready = '1;
        while (any_pending() && k < 700) begin tick(); k++; end
        tick();
        tick();
        bus.m_weight_ready = '0;
        chk("drained", bus.m_weight_valid, '0);
        chk("dcnt_zero", weight_dcnt, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_config_valid = 1'b0;
        bus.s_config_data  = '0;
        bus.s_weight_valid = 1'b0;
        bus.s_weight       = '0;
        bus.m_weight_ready = '0;
        force123   = 1'b0;
        rnd_mready = 1'b0;
        #2;
        chk("rst_cfg_ready", bus.s_config_ready, 1'b0);
        chk("rst_w_ready", bus.s_weight_ready, 1'b0);
        chk("rst_valid", bus.m_weight_valid, '0);
        chk("rst_dcnt", weight_dcnt, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_status", status, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // reset in the middle of a LOAD with beats already queued
        do_config(24'd3, 16'd64);
        new_beat();
        bus.s_weight_valid = 1'b1;
        wait_beats(5, 100);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.m_weight_valid, '0);
        chk("midrst_status", status, 3'd0);
        chk("midrst_dcnt", weight_dcnt, '0);
        chk("midrst_cfg_ready", bus.s_config_ready, 1'b0);
        chk("midrst_w_ready", bus.s_weight_ready, 1'b0);
        for (int c = 0; c < NUM_CH; c++) q[c].delete();
        beats = 0;
        dones = 0;
        bpr = NUM_CH / LANES;
        last_ch = NUM_CH - 1;
        bus.s_weight_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // two full-width rounds, lane 0 of group 0 pinned to 0x123
        force123 = 1'b1;
        do_config(24'd2, 16'd64);
        new_beat();
        bus.s_weight_valid = 1'b1;
        wait_done(200);
        chk("ch0_head", bus.m_weight_data[WW-1:0], 12'h123);
        chk("ch63_valid", bus.m_weight_valid[63], 1'b1);
        force123 = 1'b0;
        drain();

        // active_ch 20 rounds up to 24, random consumer
        do_config(24'd3, 16'd20);
        rnd_mready = 1'b1;
        new_beat();
        bus.s_weight_valid = 1'b1;
        wait_done(300);
        chk("upper_empty", bus.m_weight_valid[63:24], '0);
        drain();

        // backpressure at the programmable-full level
        do_config(24'd600, 16'd8);
        bus.m_weight_ready = '0;
        new_beat();
        bus.s_weight_valid = 1'b1;
        wait_beats(504, 1500);
        repeat (4) tick();
        chk("bp_beats", beats, 504);
        chk("bp_ready", bus.s_weight_ready, 1'b0);
        chk("bp_status", status, 3'd2);
        chk("bp_dcnt", weight_dcnt, 504);
        bus.m_weight_ready = 64'hFF;
        tick();
        bus.m_weight_ready = '0;
        chk("bp_ready_back", bus.s_weight_ready, 1'b1);
        tick();
        chk("bp_one_more", beats, 505);
        bus.m_weight_ready = '1;
        wait_done(3000);
        drain();

        // zero rounds: straight from CFG to DONE, no beats taken
        bus.s_weight_valid = 1'b1;
        new_beat();
        do_config(24'd0, 16'd8);
        wait_done(10);
        bus.s_weight_valid = 1'b0;

        // simultaneous push and pop on ch7 holding three entries
        do_config(24'd5, 16'd8);
        bus.m_weight_ready = '0;
        new_beat();
        bus.s_weight_valid = 1'b1;
        wait_beats(3, 50);
        bus.s_weight_valid = 1'b0;
        repeat (3) tick();
        chk("pp_dcnt_pre", weight_dcnt, 3);
        bus.s_weight_valid = 1'b1;
        bus.m_weight_ready = 64'h80;
        tick();
        bus.s_weight_valid = 1'b0;
        bus.m_weight_ready = '0;
        chk("pp_beat", beats, 4);
        repeat (3) tick();
        chk("pp_dcnt", weight_dcnt, 3);
        bus.s_weight_valid = 1'b1;
        wait_done(50);
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
